qspi_flash_responder: RTL



---
 rtl/qspi_flash_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: oversampled QSPI flash target serving quad fast reads from a byte memory
module qspi_flash_responder #(
   parameter int ADDR_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              qe,
   output logic              wel,
   output logic              cont_mode
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, SRW, IGNORE} state_t;
   state_t state, state_n;
   logic [5:0] sy [SYNC_STAGES];
   logic sclk_d, cs_d, rd_d, sclk_s, cs_s, rise, fall, cs_fall;
   logic [3:0] io_s, cnt, cnt_n, mh, mh_n, oe_n, out_n;
   logic [6:0] sh, sh_n;
   logic [7:0] dat;
   logic [ADDR_W-1:0] addr_n;
   logic ph, ph_n, rd_n, qe_n, wel_n, cont_n;
   assign sclk_s  = sy[SYNC_STAGES-1][5];
   assign cs_s    = sy[SYNC_STAGES-1][4];
   assign io_s    = sy[SYNC_STAGES-1][3:0];
   assign rise    = sclk_s & ~sclk_d & ~cs_s;
   assign fall    = ~sclk_s & sclk_d & ~cs_s;
   assign cs_fall = cs_d & ~cs_s;
   // synchronize {sclk, cs_n, io_in} together and keep one sample of history for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sy[i] <= 6'b010000;
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sy[0] <= {sclk, cs_n, io_in};
         for (int i = 1; i < SYNC_STAGES; i++) sy[i] <= sy[i-1];
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end
   // capture the byte returned the cycle after each read strobe and hold it for the data phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_d <= 1'b0;
         dat  <= 8'h00;
      end else begin
         rd_d <= mem_rd;
         if (rd_d) dat <= mem_data;
      end
   end
   // protocol state and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         mh        <= '0;
         ph        <= 1'b0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         io_oe     <= '0;
         io_out    <= '0;
         qe        <= 1'b0;
         wel       <= 1'b0;
         cont_mode <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sh        <= sh_n;
         mh        <= mh_n;
         ph        <= ph_n;
         mem_addr  <= addr_n;
         mem_rd    <= rd_n;
         io_oe     <= oe_n;
         io_out    <= out_n;
         qe        <= qe_n;
         wel       <= wel_n;
         cont_mode <= cont_n;
      end
   end
   // next-state: CS high aborts any transaction; otherwise each state consumes sclk edges
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      mh_n    = mh;
      ph_n    = ph;
      addr_n  = mem_addr;
      rd_n    = 1'b0;
      oe_n    = io_oe;
      out_n   = io_out;
      qe_n    = qe;
      wel_n   = wel;
      cont_n  = cont_mode;
      if (state != IDLE && cs_s) begin
         state_n = IDLE;
         cnt_n   = '0;
         oe_n    = '0;
         if (state == SRW) wel_n = 1'b0;
         if (state == ADDR || state == MODE) cont_n = 1'b0;
      end else begin
         case (state)
            IDLE: if (cs_fall) begin
               state_n = cont_mode ? ADDR : CMD;
               cnt_n   = '0;
            end
            CMD: if (rise) begin
               sh_n  = {sh[5:0], io_s[0]};
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd7) begin
                  cnt_n   = '0;
                  state_n = IGNORE;
                  case ({sh, io_s[0]})
                     8'h06:   wel_n = 1'b1;
                     8'hFF:   cont_n = 1'b0;
                     8'h01:   state_n = wel ? SRW : IGNORE;
                     8'hEB:   state_n = qe ? ADDR : IGNORE;
                     default: state_n = IGNORE;
                  endcase
               end
            end
            SRW: if (rise) begin
               sh_n  = {sh[5:0], io_s[0]};
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd15) begin
                  qe_n    = sh[0];
                  wel_n   = 1'b0;
                  state_n = IGNORE;
               end
            end
            ADDR: if (rise) begin
               addr_n = {mem_addr[ADDR_W-5:0], io_s};
               cnt_n  = cnt + 4'd1;
               if (cnt == 4'd5) begin
                  cnt_n   = '0;
                  state_n = MODE;
               end
            end
            MODE: if (rise) begin
               mh_n  = io_s;
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd1) begin
                  cont_n  = mh == 4'hA;
                  rd_n    = 1'b1;
                  cnt_n   = '0;
                  state_n = DUMMY;
               end
            end
            DUMMY: begin
               if (rise) cnt_n = cnt + 4'd1;
               if (fall && cnt == 4'd4) begin
                  oe_n    = 4'hF;
                  out_n   = dat[7:4];
                  ph_n    = 1'b0;
                  state_n = DATA;
               end
            end
            DATA: begin
               if (rise && ph) begin
                  addr_n = mem_addr + 1'b1;
                  rd_n   = 1'b1;
               end
               if (fall) begin
                  ph_n  = ~ph;
                  out_n = ph ? dat[7:4] : dat[3:0];
               end
            end
            default: oe_n = '0;
         endcase
      end
   end
endmodule
